// File: rtl/lsu.sv
// Load/store unit: one word-wide bus transaction per memory instruction,
// with lane placement, load extension, misalign detection and a bus watchdog.
module lsu #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  AccessMode,
    input  logic        LoadUnsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        Fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_n;
    logic [31:0] cnt;
    logic [1:0]  off_q;
    logic [1:0]  mode_q;
    logic        uns_q;
    logic        tofault;

    logic        req, ok, start, bad, tmo;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] sh;
    logic [31:0] ext;

    assign req = MemRead | MemWrite;

    always_comb begin
        ok = 1'b0;
        unique case (AccessMode)
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~Addr[0];
            2'b10:   ok = (Addr[1:0] == 2'b00);
            default: ok = 1'b0;
        endcase
    end

    assign start = req & ok;
    assign bad   = req & ~ok;

    always_comb begin
        strb  = 4'b1111;
        wdata = WriteData;
        unique case (AccessMode)
            2'b00: begin
                strb  = 4'b0001 << Addr[1:0];
                wdata = {4{WriteData[7:0]}};
            end
            2'b01: begin
                strb  = 4'b0011 << Addr[1:0];
                wdata = {2{WriteData[15:0]}};
            end
            default: begin
                strb  = 4'b1111;
                wdata = WriteData;
            end
        endcase
        if (!MemWrite)
            strb = 4'b0000;
    end

    // Lane shift first, then width select and extension.
    assign sh = bus_rdata >> {off_q, 3'b000};

    always_comb begin
        ext = sh;
        unique case (mode_q)
            2'b00:   ext = {{24{sh[7] & ~uns_q}}, sh[7:0]};
            2'b01:   ext = {{16{sh[15] & ~uns_q}}, sh[15:0]};
            default: ext = sh;
        endcase
    end

    assign tmo = (TIMEOUT != 0) && (cnt == TIMEOUT - 1) && !bus_ack;

    always_comb begin
        state_n = state;
        unique case (1'b1)
            state == IDLE: if (start) state_n = REQ;
            state == REQ:  if (bus_ack || tmo) state_n = DONE;
            state == DONE: state_n = IDLE;
            default:       state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= '0;
            mode_q    <= '0;
            uns_q     <= 1'b0;
            tofault   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
            ReadData  <= '0;
        end else begin
            state <= state_n;
            unique case (state)
                IDLE: begin
                    tofault <= 1'b0;
                    if (start) begin
                        cnt       <= '0;
                        off_q     <= Addr[1:0];
                        mode_q    <= AccessMode;
                        uns_q     <= LoadUnsigned;
                        bus_we    <= MemWrite;
                        bus_addr  <= {Addr[31:2], 2'b00};
                        bus_wstrb <= strb;
                        bus_wdata <= wdata;
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        if (!bus_we)
                            ReadData <= ext;
                    end else if (tmo) begin
                        ReadData <= '0;
                        tofault  <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: tofault <= 1'b0;
            endcase
        end
    end

    assign bus_req = (state == REQ);
    assign Stall   = ((state == IDLE) & start) | (state == REQ);
    assign Fault   = ((state == IDLE) & bad) | ((state == DONE) & tofault);

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu (watchdog shortened to 4 cycles).
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, LoadUnsigned;
    logic [1:0]  AccessMode;
    logic [31:0] Addr, WriteData, ReadData;
    logic        Stall, Fault, bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;

    int total  = 0;
    int passed = 0;

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .AccessMode(AccessMode), .LoadUnsigned(LoadUnsigned),
        .Addr(Addr), .WriteData(WriteData),
        .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // advance one edge; inputs settle 2 time units after it
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        MemRead = 0; MemWrite = 0; AccessMode = 2'b10;
        LoadUnsigned = 0; Addr = 0; WriteData = 0;
    endtask

    // present a request in IDLE, step into REQ, drop the request
    task automatic issue(input logic rd, input logic wr, input logic [1:0] m,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] wd);
        MemRead = rd; MemWrite = wr; AccessMode = m;
        LoadUnsigned = u; Addr = a; WriteData = wd;
        #1;
        chk("stall_n", {31'd0, Stall}, 32'd1);
        tick();
        idle_in();
        #1;
    endtask

    // acknowledge on the current REQ cycle, end in DONE
    task automatic ack(input logic [31:0] rd);
        bus_rdata = rd; bus_ack = 1;
        tick();
        bus_ack = 0; bus_rdata = 0;
        #1;
    endtask

    initial begin
        idle_in();
        bus_ack = 0; bus_rdata = 0;
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        chk("rst_req",   {31'd0, bus_req}, 32'd0);
        chk("rst_stall", {31'd0, Stall},   32'd0);
        chk("rst_fault", {31'd0, Fault},   32'd0);
        chk("rst_rdata", ReadData,          32'd0);
        chk("rst_addr",  bus_addr,          32'd0);

        // word store, ack on second REQ cycle
        issue(0, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF);
        chk("ws_req",   {31'd0, bus_req}, 32'd1);
        chk("ws_stall1", {31'd0, Stall},  32'd1);
        chk("ws_addr",  bus_addr,          32'h100);
        chk("ws_strb",  {28'd0, bus_wstrb}, 32'hF);
        chk("ws_we",    {31'd0, bus_we},   32'd1);
        chk("ws_wdata", bus_wdata,         32'hDEADBEEF);
        tick(); #1;
        chk("ws_stall2", {31'd0, Stall},  32'd1);
        ack(32'h0);
        chk("ws_done_stall", {31'd0, Stall}, 32'd0);
        chk("ws_done_fault", {31'd0, Fault}, 32'd0);
        chk("ws_done_req", {31'd0, bus_req}, 32'd0);
        chk("ws_rdata_kept", ReadData, 32'd0);
        tick();

        // signed byte load
        issue(1, 0, 2'b00, 0, 32'h203, 32'h0);
        chk("lb_addr", bus_addr, 32'h200);
        chk("lb_strb", {28'd0, bus_wstrb}, 32'd0);
        chk("lb_we",   {31'd0, bus_we},   32'd0);
        ack(32'h80FF7F01);
        chk("lb_rdata", ReadData, 32'hFFFFFF80);
        tick();

        // unsigned byte load
        issue(1, 0, 2'b00, 1, 32'h203, 32'h0);
        ack(32'h80FF7F01);
        chk("lbu_rdata", ReadData, 32'h00000080);
        tick();

        // signed half load, upper half
        issue(1, 0, 2'b01, 0, 32'h202, 32'h0);
        ack(32'h80FF7F01);
        chk("lh_rdata", ReadData, 32'hFFFF80FF);
        tick();

        // half store to upper half
        issue(0, 1, 2'b01, 0, 32'h6, 32'h1234ABCD);
        chk("hs_addr",  bus_addr, 32'h4);
        chk("hs_strb",  {28'd0, bus_wstrb}, 32'hC);
        chk("hs_wdata", bus_wdata, 32'hABCDABCD);
        ack(32'h0);
        chk("hs_rdata_kept", ReadData, 32'hFFFF80FF);
        tick();

        // byte store to lane 1
        issue(0, 1, 2'b00, 0, 32'h11, 32'h000000A5);
        chk("bs_strb",  {28'd0, bus_wstrb}, 32'h2);
        chk("bs_wdata", bus_wdata, 32'hA5A5A5A5);
        ack(32'h0);
        tick();

        // misaligned word load
        MemRead = 1; AccessMode = 2'b10; Addr = 32'h102;
        #1;
        chk("mis_fault", {31'd0, Fault}, 32'd1);
        chk("mis_stall", {31'd0, Stall}, 32'd0);
        tick();
        idle_in();
        #1;
        chk("mis_fault_clr", {31'd0, Fault}, 32'd0);
        chk("mis_req", {31'd0, bus_req}, 32'd0);

        // illegal access mode
        MemRead = 1; AccessMode = 2'b11; Addr = 32'h100;
        #1;
        chk("ill_fault", {31'd0, Fault}, 32'd1);
        chk("ill_stall", {31'd0, Stall}, 32'd0);
        tick();
        idle_in();
        #1;
        chk("ill_req", {31'd0, bus_req}, 32'd0);
        chk("ill_fault_clr", {31'd0, Fault}, 32'd0);

        // watchdog: four REQ cycles then DONE with fault
        issue(1, 0, 2'b10, 0, 32'h300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_req%0d", i), {31'd0, bus_req}, 32'd1);
            chk($sformatf("to_fault%0d", i), {31'd0, Fault}, 32'd0);
            tick(); #1;
        end
        chk("to_req_drop", {31'd0, bus_req}, 32'd0);
        chk("to_fault", {31'd0, Fault}, 32'd1);
        chk("to_stall", {31'd0, Stall}, 32'd0);
        chk("to_rdata", ReadData, 32'd0);
        tick();
        bus_ack = 1; bus_rdata = 32'h12345678;
        #1;
        chk("stray_fault", {31'd0, Fault}, 32'd0);
        chk("stray_stall", {31'd0, Stall}, 32'd0);
        tick();
        bus_ack = 0; bus_rdata = 0;
        #1;
        chk("stray_req", {31'd0, bus_req}, 32'd0);
        chk("stray_rdata", ReadData, 32'd0);

        // reset in the middle of REQ
        issue(1, 0, 2'b10, 0, 32'h104, 32'h0);
        chk("mr_req", {31'd0, bus_req}, 32'd1);
        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("mr_req_clr", {31'd0, bus_req}, 32'd0);
        chk("mr_stall", {31'd0, Stall}, 32'd0);
        chk("mr_addr", bus_addr, 32'd0);

        // normal load after reset
        issue(1, 0, 2'b10, 1, 32'h108, 32'h0);
        chk("pr_addr", bus_addr, 32'h108);
        ack(32'hCAFEF00D);
        chk("pr_rdata", ReadData, 32'hCAFEF00D);
        chk("pr_stall", {31'd0, Stall}, 32'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly downstream of the main decoder: consumes its MemWrite, load indication (ResultSrc = 01) and AccessMode, plus the ALU address and rs2 data, and performs one word-wide data-bus transaction per memory instruction. Handles byte/half/word lane placement, strobes, load sign/zero extension and misalignment detection. Stalls the core until the access completes or a bus timeout fires.

## Interface
- TIMEOUT, 16: max cycles in REQ waiting for bus_ack before aborting; 0 disables the watchdog.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MemRead  in  1  load request (decoder ResultSrc == 01).
- MemWrite  in  1  store request from decoder.
- AccessMode  in  2  00 byte, 01 half, 10 word, 11 illegal.
- LoadUnsigned  in  1  funct3[2]; 1 = zero-extend (lbu/lhu).
- Addr  in  32  byte address from ALU.
- WriteData  in  32  store data (rs2).
- ReadData  out  32  extended load result; registered.
- Stall  out  1  hold PC/pipeline this cycle.
- Fault  out  1  one-cycle pulse: misaligned, illegal mode, or timeout.
- bus_req  out  1  transaction request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word-aligned address ({Addr[31:2],2'b00}).
- bus_wstrb  out  4  byte enables (0000 on reads).
- bus_wdata  out  32  lane-replicated write data.
- bus_rdata  in  32  read data, valid when bus_ack = 1.
- bus_ack  in  1  transaction complete.

## Operation
- States: IDLE, REQ, DONE.
- start = (MemRead | MemWrite) & aligned & AccessMode != 11. MemRead and MemWrite both high: treated as a write.
- aligned: byte always; half needs Addr[0] = 0; word needs Addr[1:0] = 00.
- IDLE, start: capture bus_addr, bus_we, bus_wstrb, bus_wdata, Addr[1:0], AccessMode, LoadUnsigned; clear timeout counter; -> REQ.
- IDLE, request but misaligned or mode 11: no bus activity, Fault = 1 this cycle, Stall = 0, stay IDLE.
- REQ: bus_req = 1, all bus outputs held stable. bus_ack = 1: on load, register extended data into ReadData; -> DONE. Counter increments each REQ cycle without ack; counter reaching TIMEOUT-1 with no ack (TIMEOUT != 0): -> DONE with Fault pulse in DONE, ReadData = 0.
- DONE: Stall = 0, ReadData valid; -> IDLE unconditionally.
- Write lanes: byte wdata = {4{WriteData[7:0]}}, wstrb = 0001 << Addr[1:0]; half wdata = {2{WriteData[15:0]}}, wstrb = 0011 << Addr[1:0]; word wdata = WriteData, wstrb = 1111.
- Load extract: shift bus_rdata right by 8*Addr[1:0]; byte takes [7:0], half [15:0], word [31:0]; upper bits = 0 if LoadUnsigned else sign bit. LoadUnsigned ignored for word.
- Stores leave ReadData unchanged.

## Timing
- Stall = (IDLE & start) | REQ; combinational.
- Request seen in IDLE at cycle N -> bus_req high from N+1; ack sampled at cycle M >= N+1 -> DONE at M+1 with ReadData valid; min latency 3 cycles, Stall high N..M.
- bus_ack outside REQ ignored (late ack after reset or timeout has no effect).
- Back-to-back: DONE -> IDLE; next request can start the cycle after DONE.
- Timeout: bus_req drops in the cycle after the final waiting cycle; Fault pulses in DONE.
- Reset (any state, including mid-REQ): next cycle IDLE; bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata, ReadData, counter = 0; Fault = 0; Stall = 0 unless a request is presented.

## Test plan
- Word store Addr=0x100, WriteData=0xDEADBEEF, ack after 2 REQ cycles -> bus_addr 0x100, wstrb 1111, we 1, Stall 3 cycles, no Fault.
- Byte loads Addr=0x203 with bus_rdata=0x80FF7F01: signed -> ReadData 0xFFFFFF80; unsigned -> 0x00000080; half load Addr=0x202 signed -> 0xFFFF80FF.
- Half store Addr=0x6, WriteData=0x1234ABCD -> bus_addr 0x4, wstrb 1100, wdata 0xABCDABCD.
- Misaligned word load Addr=0x102, and AccessMode 11 -> Fault one cycle, bus_req never high, Stall 0.
- TIMEOUT=4, no ack -> bus_req high 4 cycles, then DONE with Fault, ReadData 0; later stray ack ignored.
- Reset asserted during REQ -> bus_req 0 next cycle, state IDLE; following word load completes normally.
